// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if
//   Bundles the register-file access bus: clear request, two write ports,
//   NREAD packed read ports, busy flag and the FSM debug state.
//
//   Handshake: there is no valid/ready pair. The master may present a write
//   (weN_i) or a clear (clr_i) in any cycle. While busy_o is high, every
//   write is silently dropped and all rd_o lanes read 0. The master stalls
//   on busy_o.
//
//   Modports
//     master : drives clr/we/wa/wd/ra, observes rd_o, busy_o, state_dbg
//     slave  : the register file itself
// ---------------------------------------------------------------------------
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic                     clr_i;
  logic                     we0_i;
  logic [ADDR_W-1:0]        wa0_i;
  logic [DATA_W-1:0]        wd0_i;
  logic                     we1_i;
  logic [ADDR_W-1:0]        wa1_i;
  logic [DATA_W-1:0]        wd1_i;
  logic [NREAD*ADDR_W-1:0]  ra_i;
  logic [NREAD*DATA_W-1:0]  rd_o;
  logic                     busy_o;
  logic                     state_dbg;  // 0 = IDLE, 1 = CLEAR

  modport master (
    output clr_i, we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i, ra_i,
    input  rd_o, busy_o, state_dbg
  );

  modport slave (
    input  clr_i, we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i, ra_i,
    output rd_o, busy_o, state_dbg
  );
endinterface

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-port register file: two write ports, NREAD combinational read
//   ports, optional hardwired-zero entry 0. The array is never reset
//   directly; a sweep engine clears one entry per cycle after reset or on a
//   clr_i pulse, so the storage can map onto RAM.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : synchronous reset, active-high (starts a clear sweep)
//     bus  : regfile_mp_if.slave (clr, 2 write ports, read ports, busy_o,
//            state_dbg)
//
//   Optional feature (macro RF_BYPASS_EN):
//     defined   -> a read matching an active same-cycle write returns the
//                  write data combinationally (port 1 has priority)
//     undefined -> reads return stored contents only
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic w0_en, w1_en, clr_en;

  // Next-state: the sweep visits every entry exactly once; clr_i during a
  // sweep is ignored because CLEAR never looks at it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == '1) state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Writes commit only in IDLE, and a clear request in the same cycle wins.
  always_comb begin
    clr_en = (state_q == CLEAR);
    w0_en  = (state_q == IDLE) && !rst && !bus.clr_i && bus.we0_i &&
             !((ZERO_REG != 0) && (bus.wa0_i == '0));
    w1_en  = (state_q == IDLE) && !rst && !bus.clr_i && bus.we1_i &&
             !((ZERO_REG != 0) && (bus.wa1_i == '0));
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (w0_en) mem_q[bus.wa0_i] <= bus.wd0_i;
      if (w1_en) mem_q[bus.wa1_i] <= bus.wd1_i;
    end
  end

  always_comb begin
    bus.rd_o = '0;
    for (int k = 0; k < NREAD; k++) begin
      bus.rd_o[k*DATA_W +: DATA_W] = mem_q[bus.ra_i[k*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
      if (w0_en && (bus.wa0_i == bus.ra_i[k*ADDR_W +: ADDR_W]))
        bus.rd_o[k*DATA_W +: DATA_W] = bus.wd0_i;
      if (w1_en && (bus.wa1_i == bus.ra_i[k*ADDR_W +: ADDR_W]))
        bus.rd_o[k*DATA_W +: DATA_W] = bus.wd1_i;
`endif
      if ((state_q == CLEAR) ||
          ((ZERO_REG != 0) && (bus.ra_i[k*ADDR_W +: ADDR_W] == '0)))
        bus.rd_o[k*DATA_W +: DATA_W] = '0;
    end
  end

  assign bus.busy_o    = (state_q == CLEAR);
  assign bus.state_dbg = state_q;

endmodule
